// File: rtl/layer_output_reader_pkg.sv
// rtl/layer_output_reader_pkg.sv - shared network package: reader FSM states and layer defaults
package layer_output_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_NUMBER_OF_NODE = 32;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_STREAM  = 1'b1
  } state_e;

endpackage

// File: rtl/layer_output_reader.sv
// rtl/layer_output_reader.sv - captures one result per node, then streams them out in node order
module layer_output_reader
  import layer_output_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUMBER_OF_NODE = DEFAULT_NUMBER_OF_NODE,
  parameter int INDEX_WIDTH    = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUMBER_OF_NODE-1:0]            i_node_valid,
  input  logic [NUMBER_OF_NODE*DATA_WIDTH-1:0] i_node_data,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic [INDEX_WIDTH-1:0]               o_index,
  output logic                                 o_last,
  output logic                                 o_done,
  output logic                                 o_overrun
);

  localparam int SEL_W = (NUMBER_OF_NODE > 1) ? $clog2(NUMBER_OF_NODE) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUMBER_OF_NODE - 1);

  state_e                    state_q, state_d;
  logic [NUMBER_OF_NODE-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0]     bank_q [NUMBER_OF_NODE];
  logic [DATA_WIDTH-1:0]     bank_d [NUMBER_OF_NODE];
  logic [INDEX_WIDTH-1:0]    index_q, index_d;
  logic                      done_q, done_d;
  logic                      overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    bank_d    = bank_q;
    index_d   = index_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      ST_COLLECT: begin
        // First strobe wins; later strobes for a captured node are dropped silently.
        for (int k = 0; k < NUMBER_OF_NODE; k++) begin
          if (i_node_valid[k] && !mask_q[k]) begin
            bank_d[k] = i_node_data[k*DATA_WIDTH +: DATA_WIDTH];
            mask_d[k] = 1'b1;
          end
        end
        if (&mask_d) begin
          state_d = ST_STREAM;
          index_d = '0;
        end
      end
      ST_STREAM: begin
        if (|i_node_valid) begin
          overrun_d = 1'b1;
        end
        if (i_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = ST_COLLECT;
            mask_d  = '0;
            index_d = '0;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + INDEX_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      mask_q    <= '0;
      index_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUMBER_OF_NODE; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      bank_q    <= bank_d;
      index_q   <= index_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_valid   = (state_q == ST_STREAM);
  assign o_data    = o_valid ? bank_q[index_q[SEL_W-1:0]] : '0;
  assign o_index   = index_q;
  assign o_last    = o_valid && (index_q == LAST_IDX);
  assign o_done    = done_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_layer_output_reader.sv
// tb/tb_layer_output_reader.sv - scoreboard bench for layer_output_reader with four nodes
module tb_layer_output_reader;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    i_node_valid;
  logic [N*DW-1:0] i_node_data;
  logic            o_valid;
  logic            i_ready;
  logic [DW-1:0]   o_data;
  logic [IW-1:0]   o_index;
  logic            o_last;
  logic            o_done;
  logic            o_overrun;

  layer_output_reader #(
    .DATA_WIDTH(DW), .NUMBER_OF_NODE(N), .INDEX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_node_valid(i_node_valid), .i_node_data(i_node_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_index(o_index),
    .o_last(o_last), .o_done(o_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mbank [N];
  logic [N-1:0]  mmask = '0;
  int            total = 0;
  int            passed = 0;
  int            failed = 0;
  int            xfers = 0;
  logic          hold_pending = 1'b0;
  logic [DW-1:0] held_d;
  logic [IW-1:0] held_i;
  logic          held_l;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Inspect the cycle at the falling edge, then advance past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (hold_pending) begin
      chk("hold_data", o_data, held_d);
      chk("hold_index", DW'(o_index), DW'(held_i));
      chk("hold_last", DW'(o_last), DW'(held_l));
      hold_pending = 1'b0;
    end
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_xfer", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("xfer_data", o_data, e.d);
        chk("xfer_index", DW'(o_index), DW'(e.i));
        chk("xfer_last", DW'(o_last), DW'(e.l));
        xfers++;
      end
    end else if (o_valid === 1'b1) begin
      held_d = o_data;
      held_i = o_index;
      held_l = o_last;
      hold_pending = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [N-1:0] v, input logic [N*DW-1:0] d);
    exp_t e;
    i_node_valid = v;
    i_node_data  = d;
    for (int k = 0; k < N; k++) begin
      if (v[k] && !mmask[k]) begin
        mbank[k] = d[k*DW +: DW];
        mmask[k] = 1'b1;
      end
    end
    if (&mmask) begin
      for (int k = 0; k < N; k++) begin
        e.d = mbank[k];
        e.i = IW'(k);
        e.l = (k == N - 1);
        sb.push_back(e);
      end
      mmask = '0;
    end
    tick();
    i_node_valid = '0;
  endtask

  task automatic drain(input bit toggle);
    int budget = 40;
    int n = 0;
    while (sb.size() > 0 && budget > 0) begin
      i_ready = toggle ? ((n % 2) == 0) : 1'b1;
      tick();
      n++;
      budget--;
    end
    chk("drain_left", DW'(sb.size()), 32'd0);
    i_ready = 1'b1;
    chk("done_pulse", DW'(o_done), 32'd1);
    chk("valid_after_pass", DW'(o_valid), 32'd0);
  endtask

  function automatic logic [N*DW-1:0] pack4(input logic [DW-1:0] base);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = base ^ DW'(k * 32'h0101_0101);
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int x0;
    logic [N*DW-1:0] d;
    rst_n = 1'b0;
    i_ready = 1'b1;
    i_node_valid = '0;
    i_node_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", DW'(o_valid), 32'd0);
    chk("rst_index", DW'(o_index), 32'd0);
    chk("rst_last", DW'(o_last), 32'd0);
    chk("rst_done", DW'(o_done), 32'd0);
    chk("rst_overrun", DW'(o_overrun), 32'd0);
    chk("rst_data", o_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // One node per cycle.
    d = pack4(32'hA0A0_0000);
    for (int k = 0; k < N; k++) begin
      strobe(N'(1 << k), d);
      if (k < N - 1) chk("collect_valid", DW'(o_valid), 32'd0);
    end
    chk("stream_start_valid", DW'(o_valid), 32'd1);
    chk("stream_start_index", DW'(o_index), 32'd0);
    drain(1'b0);
    tick();
    chk("done_one_cycle", DW'(o_done), 32'd0);

    // All at once with a stalling consumer.
    x0 = xfers;
    strobe(4'b1111, pack4(32'h5EED_1234));
    drain(1'b1);
    chk("stall_xfer_count", DW'(xfers - x0), 32'd4);

    // Duplicate strobe on node 2 keeps the first word.
    strobe(4'b0100, pack4(32'hBBBB_0000));
    strobe(4'b0100, pack4(32'hCCCC_0000));
    strobe(4'b1011, pack4(32'hDDDD_0000));
    drain(1'b0);
    chk("dup_no_overrun", DW'(o_overrun), 32'd0);

    // Strobe during streaming raises the sticky overrun.
    strobe(4'b1111, pack4(32'h1357_9BDF));
    i_ready = 1'b0;
    i_node_valid = 4'b0010;
    i_node_data = pack4(32'hDEAD_BEEF);
    tick();
    i_node_valid = '0;
    chk("overrun_set", DW'(o_overrun), 32'd1);
    drain(1'b0);
    tick();
    chk("overrun_sticky", DW'(o_overrun), 32'd1);

    // Reset mid-stream abandons the pass.
    strobe(4'b1111, pack4(32'h2468_ACE0));
    i_ready = 1'b1;
    tick();
    tick();
    chk("pre_reset_index", DW'(o_index), 32'd2);
    i_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    hold_pending = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    mmask = '0;
    chk("midrst_valid", DW'(o_valid), 32'd0);
    chk("midrst_index", DW'(o_index), 32'd0);
    chk("midrst_overrun", DW'(o_overrun), 32'd0);
    i_ready = 1'b1;
    tick();
    chk("midrst_no_done", DW'(o_done), 32'd0);
    strobe(4'b1111, pack4(32'h0F0F_F0F0));
    drain(1'b0);

    // Back-to-back passes, second capture on the done cycle.
    strobe(4'b1111, pack4(32'h7777_0001));
    drain(1'b0);
    strobe(4'b1111, pack4(32'h8888_0002));
    chk("b2b_valid", DW'(o_valid), 32'd1);
    chk("b2b_index", DW'(o_index), 32'd0);
    drain(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
